// File: rtl/accel_pkg.sv
// Shared widths and saturation bounds for the accelerator activation paths.
package accel_pkg;

  localparam int PSUM_W  = 32;
  localparam int ACT_W   = 8;
  localparam int SHIFT_W = 5;

  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/requant_sat.sv
// Combinational ReLU + signed clamp of a wide requantized value to OUT_W bits.
module requant_sat
  import accel_pkg::*;
#(
  parameter int QW    = PSUM_W + 1,
  parameter int OUT_W = ACT_W
) (
  input  logic signed [QW-1:0]    q,
  input  logic                    relu,
  output logic        [OUT_W-1:0] result,
  output logic                    sat_flag
);

  localparam logic signed [QW-1:0] MAXV = QW'(sat_max(OUT_W));
  localparam logic signed [QW-1:0] MINV = QW'(sat_min(OUT_W));

  // ReLU wins over clamping: a negative value zeroed by ReLU is not a saturation event.
  always_comb begin
    result   = q[OUT_W-1:0];
    sat_flag = 1'b0;
    if (relu && q[QW-1]) begin
      result = '0;
    end else if (q > MAXV) begin
      result   = MAXV[OUT_W-1:0];
      sat_flag = 1'b1;
    end else if (q < MINV) begin
      result   = MINV[OUT_W-1:0];
      sat_flag = 1'b1;
    end
  end

endmodule

// File: rtl/psum_requant.sv
// Two-stage requantizer for 32-bit partial sums: round + shift, then ReLU/clamp,
// with valid/ready on both sides and a sticky saturation-event counter.
module psum_requant
  import accel_pkg::*;
#(
  parameter int IN_W  = PSUM_W,
  parameter int OUT_W = ACT_W,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [IN_W-1:0]    s_data,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic               cfg_relu,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [OUT_W-1:0]   m_data,
  output logic [CNT_W-1:0]   sat_cnt,
  input  logic               sat_clr
);

  // One extra bit so sum + rounding constant can never wrap.
  localparam int QW = IN_W + 1;

  logic                    v1_q, v1_d, v2_q, v2_d;
  logic signed [QW-1:0]    q1_q, q1_d;
  logic                    relu1_q, relu1_d;
  logic        [OUT_W-1:0] data2_q, data2_d;
  logic        [CNT_W-1:0] cnt_q, cnt_d;

  logic                    adv1, adv2;
  logic signed [QW-1:0]    sx, rnd, t, q_s;
  logic        [OUT_W-1:0] res;
  logic                    sat;

  assign adv2    = !v2_q || m_ready;
  assign adv1    = !v1_q || adv2;
  assign s_ready = adv1;
  assign m_valid = v2_q;
  assign m_data  = data2_q;
  assign sat_cnt = cnt_q;

  always_comb begin
    sx  = $signed({s_data[IN_W-1], s_data});
    rnd = '0;
    if (cfg_shift != '0) rnd = QW'(1) << (cfg_shift - SHIFT_W'(1));
    t   = sx + rnd;
    q_s = t >>> cfg_shift;
  end

  requant_sat #(.QW(QW), .OUT_W(OUT_W)) u_sat (
    .q        (q1_q),
    .relu     (relu1_q),
    .result   (res),
    .sat_flag (sat)
  );

  always_comb begin
    v1_d    = v1_q;
    q1_d    = q1_q;
    relu1_d = relu1_q;
    v2_d    = v2_q;
    data2_d = data2_q;
    cnt_d   = cnt_q;
    if (adv1) begin
      v1_d = s_valid;
      if (s_valid) begin
        q1_d    = q_s;
        relu1_d = cfg_relu;
      end
    end
    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) data2_d = res;
    end
    // Clear beats a same-edge increment; the count sticks at all-ones.
    if (sat_clr)                                   cnt_d = '0;
    else if (adv2 && v1_q && sat && cnt_q != '1)   cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      q1_q    <= '0;
      relu1_q <= 1'b0;
      v2_q    <= 1'b0;
      data2_q <= '0;
      cnt_q   <= '0;
    end else begin
      v1_q    <= v1_d;
      q1_q    <= q1_d;
      relu1_q <= relu1_d;
      v2_q    <= v2_d;
      data2_q <= data2_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_psum_requant.sv
// Randomized + directed bench for psum_requant against an integer reference model.
module tb_psum_requant;

  localparam int OW = 8;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [31:0]   s_data = '0;
  logic [4:0]    cfg_shift = '0;
  logic          cfg_relu = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [OW-1:0] m_data;
  logic [CW-1:0] sat_cnt;
  logic          sat_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  int cnt_exp = 0;
  logic [OW-1:0] expq[$];

  logic [31:0]   td[8]   = '{32'd280, 32'hFFFFFFE8, 32'hFFFFFFE8, 32'hFFFFFFF8,
                             32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000000};
  int            tsh[8]  = '{4, 4, 4, 4, 0, 0, 31, 0};
  bit            trl[8]  = '{0, 0, 1, 0, 0, 0, 0, 1};
  logic [OW-1:0] texp[8] = '{8'd18, 8'hFF, 8'h00, 8'h00, 8'h7F, 8'h80, 8'h01, 8'h00};
  int            tcnt[8] = '{0, 0, 0, 0, 1, 2, 2, 2};

  psum_requant #(.IN_W(32), .OUT_W(OW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .cfg_shift (cfg_shift),
    .cfg_relu  (cfg_relu),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .sat_cnt   (sat_cnt),
    .sat_clr   (sat_clr)
  );

  always #5 clk = ~clk;

  // Returns {sat_event, result} using plain 64-bit integer arithmetic.
  function automatic logic [OW:0] model(input logic [31:0] sd, input int sh, input bit relu);
    longint t, q, mx, mn;
    mx = (longint'(1) << (OW - 1)) - 1;
    mn = -(longint'(1) << (OW - 1));
    t  = longint'($signed(sd));
    if (sh > 0) t = t + (longint'(1) << (sh - 1));
    q = t >>> sh;
    if (relu && q < 0) return {1'b0, OW'(0)};
    if (q > mx)        return {1'b1, OW'(mx)};
    if (q < mn)        return {1'b1, OW'(mn)};
    return {1'b0, OW'(q)};
  endfunction

  function automatic void bump();
    if (cnt_exp < (1 << CW) - 1) cnt_exp++;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_mvalid: got %0b want 0", m_valid); end
    checks++;
    if (m_data !== '0) begin errors++; $display("FAIL reset_mdata: got %0h want 0", m_data); end
    checks++;
    if (sat_cnt !== '0) begin errors++; $display("FAIL reset_satcnt: got %0h want 0", sat_cnt); end
    rst_n = 1'b1;
    cyc();
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_sready: got %0b want 1", s_ready); end
    cnt_exp = 0;
  endtask

  task automatic test_directed();
    logic [OW:0] r;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_valid   = 1'b1;
      s_data    = td[i];
      cfg_shift = 5'(tsh[i]);
      cfg_relu  = trl[i];
      r = model(td[i], tsh[i], trl[i]);
      if (r[OW]) bump();
      cyc();
      s_valid = 1'b0;
      checks++;
      if (m_valid !== 1'b0) begin errors++; $display("FAIL dir_latency[%0d]: m_valid got %0b want 0", i, m_valid); end
      cyc();
      checks++;
      if (m_valid !== 1'b1 || m_data !== texp[i]) begin
        errors++;
        $display("FAIL dir_data[%0d]: got v=%0b %0h want v=1 %0h", i, m_valid, m_data, texp[i]);
      end
      checks++;
      if (sat_cnt !== CW'(tcnt[i])) begin
        errors++;
        $display("FAIL dir_satcnt[%0d]: got %0d want %0d", i, sat_cnt, tcnt[i]);
      end
      cyc();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d[6];
    int sh[6];
    int sent = 0, got = 0, first_out = -1, last_out = -1;
    logic [OW:0] r;
    for (int i = 0; i < 6; i++) begin
      d[i]  = 32'($urandom_range(0, 4000)) - 32'd2000;
      sh[i] = $urandom_range(0, 8);
    end
    for (int c = 0; c < 40 && got < 6; c++) begin
      m_ready = (c >= 4);
      s_valid = (sent < 6);
      if (sent < 6) begin
        s_data = d[sent]; cfg_shift = 5'(sh[sent]); cfg_relu = 1'b0;
      end
      #1;
      if (c == 2 || c == 3) begin
        checks++;
        if (s_ready !== 1'b0 || sent != 2) begin
          errors++;
          $display("FAIL bp_sready[c%0d]: s_ready=%0b accepted=%0d want 0/2", c, s_ready, sent);
        end
        checks++;
        if (m_valid !== 1'b1 || m_data !== expq[0]) begin
          errors++;
          $display("FAIL bp_hold[c%0d]: got v=%0b %0h want v=1 %0h", c, m_valid, m_data, expq[0]);
        end
      end
      if (s_valid && s_ready) begin
        r = model(d[sent], sh[sent], 1'b0);
        expq.push_back(r[OW-1:0]);
        if (r[OW]) bump();
        sent++;
      end
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== expq[0]) begin
          errors++;
          $display("FAIL bp_order[%0d]: got %0h want %0h", got, m_data, expq[0]);
        end
        void'(expq.pop_front());
        got++;
        if (first_out < 0) first_out = c;
        last_out = c;
      end
      cyc();
    end
    s_valid = 1'b0;
    checks++;
    if (got != 6 || first_out != 4 || last_out != 9) begin
      errors++;
      $display("FAIL bp_rate: got %0d beats cycles %0d..%0d want 6 beats cycles 4..9", got, first_out, last_out);
    end
  endtask

  task automatic test_random();
    localparam int N = 300;
    int sent = 0, got = 0, c = 0;
    logic [31:0] d;
    int sh;
    bit rl;
    logic [OW:0] r;
    expq.delete();
    while (c < 3000 && (sent < N || expq.size() > 0)) begin
      s_valid = (sent < N) && ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       d = $urandom;
        1:       d = 32'($urandom_range(0, 2000)) - 32'd1000;
        2:       d = $urandom_range(0, 1) ? 32'h7FFFFFFF : 32'h80000000;
        default: d = 32'($urandom_range(0, 65535)) - 32'd32768;
      endcase
      sh = $urandom_range(0, 1) ? $urandom_range(0, 8) : $urandom_range(0, 31);
      rl = 1'($urandom_range(0, 1));
      s_data = d; cfg_shift = 5'(sh); cfg_relu = rl;
      #1;
      if (s_valid && s_ready) begin
        r = model(d, sh, rl);
        expq.push_back(r[OW-1:0]);
        if (r[OW]) bump();
        sent++;
      end
      if (m_valid && m_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL rnd_spurious: unexpected beat %0h", m_data);
        end else begin
          if (m_data !== expq[0]) begin
            errors++;
            $display("FAIL rnd_data[%0d]: got %0h want %0h", got, m_data, expq[0]);
          end
          void'(expq.pop_front());
        end
        got++;
      end
      cyc();
      c++;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    checks++;
    if (sent != N || expq.size() != 0) begin
      errors++;
      $display("FAIL rnd_timeout: sent %0d pending %0d want %0d/0", sent, expq.size(), N);
    end
    checks++;
    if (sat_cnt !== CW'(cnt_exp)) begin
      errors++;
      $display("FAIL rnd_satcnt: got %0d want %0d", sat_cnt, cnt_exp);
    end
  endtask

  task automatic test_sat_sticky();
    sat_clr = 1'b1;
    cyc();
    sat_clr = 1'b0;
    cnt_exp = 0;
    checks++;
    if (sat_cnt !== '0) begin errors++; $display("FAIL clr_idle: got %0d want 0", sat_cnt); end
    m_ready = 1'b1;
    s_data = 32'h7FFFFFFF; cfg_shift = '0; cfg_relu = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < (1 << CW) + 5; i++) begin
      bump();
      cyc();
    end
    s_valid = 1'b0;
    cyc();
    cyc();
    checks++;
    if (sat_cnt !== CW'(cnt_exp) || cnt_exp != (1 << CW) - 1) begin
      errors++;
      $display("FAIL sat_sticky: got %0h want %0h", sat_cnt, (1 << CW) - 1);
    end
    s_data = 32'h80000000;
    s_valid = 1'b1;
    cyc();
    s_valid = 1'b0;
    sat_clr = 1'b1;
    cyc();
    sat_clr = 1'b0;
    cnt_exp = 0;
    checks++;
    if (sat_cnt !== '0 || m_valid !== 1'b1 || m_data !== 8'h80) begin
      errors++;
      $display("FAIL clr_priority: cnt=%0d v=%0b data=%0h want 0/1/80", sat_cnt, m_valid, m_data);
    end
    cyc();
    checks++;
    if (sat_cnt !== '0) begin errors++; $display("FAIL clr_hold: got %0d want 0", sat_cnt); end
  endtask

  task automatic test_reset_midstream();
    int stale = 0;
    m_ready = 1'b0;
    s_data = 32'h7FFFFFFF; cfg_shift = '0; cfg_relu = 1'b0;
    s_valid = 1'b1;
    cyc();
    s_data = 32'd1000;
    cyc();
    s_valid = 1'b0;
    rst_n = 1'b0;
    cyc();
    checks++;
    if (m_valid !== 1'b0 || m_data !== '0 || sat_cnt !== '0) begin
      errors++;
      $display("FAIL rst_mid: v=%0b data=%0h cnt=%0d want 0/0/0", m_valid, m_data, sat_cnt);
    end
    rst_n = 1'b1;
    m_ready = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_sready: got %0b want 1", s_ready); end
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (m_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin errors++; $display("FAIL rst_mid_stale: %0d stale cycles want 0", stale); end
    expq.delete();
    cnt_exp = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_sat_sticky();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/psum_requant.md
Name: psum_requant

Overview:
- Consumer end of the 32-bit signed partial-sum path in the accelerator datapath.
- Accepts registered 32-bit signed sums from the adder stage and requantizes each one to OUT_W bits for the activation buffer.
- Per beat: round, arithmetic right-shift, optional ReLU, saturation.
- Valid/ready handshake on both sides; 2-stage pipeline; throughput of one beat per cycle; running saturation-event counter.

Parameters:
- IN_W, 32, input partial-sum width (signed).
- OUT_W, 8, output activation width (signed); legal range 2..16.
- CNT_W, 16, width of the saturation-event counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- s_valid  input  1  input beat valid.
- s_ready  output  1  block can accept an input beat.
- s_data  input  IN_W  signed partial sum.
- cfg_shift  input  5  right-shift amount, 0..31.
- cfg_relu  input  1  1 = clamp negative results to 0.
- m_valid  output  1  output beat valid.
- m_ready  input  1  downstream accepts the output beat.
- m_data  output  OUT_W  signed requantized value.
- sat_cnt  output  CNT_W  count of saturated beats; saturates at all-ones.
- sat_clr  input  1  synchronous clear of sat_cnt.

Behaviour:
- Reset: the clock edge with rst_n=0 sets m_valid=0, m_data=0, sat_cnt=0 and both stage-valid flags to 0. s_ready is 1 from the first cycle after reset.
- Reset mid-stream: all in-flight beats are discarded; no output beat is produced for them.
- Handshake: a transfer occurs on a clock edge where valid and ready are both 1.
  - m_valid, once high, holds with m_data stable until m_ready=1.
  - m_valid does not depend combinationally on m_ready.
- Pipeline control:
  - adv2 = !v2 || m_ready.
  - adv1 = !v1 || adv2.
  - s_ready = adv1 (combinational).
  - A full pipe with m_ready=0 holds 2 beats, and s_ready=0.
- Latency: 2 cycles from input acceptance to m_valid when m_ready is held high; sustained rate 1 beat/cycle.
- Stage 1 (captured on input acceptance):
  - cfg_shift and cfg_relu are sampled with the beat and travel with it, so config changes take effect per beat.
  - rnd = (shift==0) ? 0 : 1 << (shift-1).
  - t = sext33(s_data) + rnd, computed in 33 bits; t never wraps.
  - q = t >>> shift (arithmetic shift), kept in 33 bits.
- Stage 2 (when adv2):
  - If relu is set and q < 0, the result is 0 and this is not a saturation event.
  - Else if q > 2^(OUT_W-1)-1, the result is 2^(OUT_W-1)-1 and this is a saturation event.
  - Else if q < -2^(OUT_W-1), the result is -2^(OUT_W-1) and this is a saturation event.
  - Else the result is q[OUT_W-1:0].
- Rounding mode is round-half-up toward +inf (e.g. -8>>>4 with rnd=8 gives 0).
- sat_cnt:
  - Increments by 1 when a beat that saturated enters stage 2.
  - Holds at 2^CNT_W-1 instead of wrapping.
  - sat_clr=1 forces 0 on that edge and takes priority over a same-cycle increment.
- Simultaneous input accept and output transfer in one cycle is legal and loses no beat. Beat order is always preserved.

Decomposition:
- Shared package (accel_pkg): PSUM_W=32, ACT_W=8, SHIFT_W=5, and the saturation min/max constants as functions of OUT_W.
- One natural sub-module: requant_sat, the combinational stage-2 ReLU/clamp logic (inputs q, relu; outputs result, sat_flag). It is reusable by the other activation paths.
- Pipeline registers and handshake stay in psum_requant.

Test Plan:
- shift=4, relu=0, s_data=280 -> m_data=18 two cycles later. sat_cnt stays 0.
- shift=4, s_data=-24 -> relu=0 gives m_data=-1 (0xFF); relu=1 gives m_data=0. sat_cnt=0 in both cases.
- shift=0, s_data=0x7FFFFFFF -> m_data=127, sat_cnt=1. Then s_data=0x80000000 -> m_data=-128, sat_cnt=2. Then shift=31, s_data=0x7FFFFFFF -> m_data=1 (33-bit rounding, no wrap), sat_cnt unchanged.
- Backpressure: stream 6 beats with s_valid continuously high and m_ready=0 for 4 cycles.
  - s_ready drops after 2 beats accepted.
  - m_data holds stable while stalled.
  - After m_ready returns to 1, all 6 results emerge in order, 1 per cycle.
- sat_cnt preset near 0xFFFF via a stream of saturating beats -> it sticks at 0xFFFF. sat_clr asserted in the same cycle as a saturating beat -> sat_cnt=0.
- Reset mid-stream: rst_n low 1 cycle with 2 beats in flight -> m_valid=0 and m_data=0 the next cycle, no stale beat emitted later, s_ready=1.
